// File: rtl/ddr3_dec_pkg.sv
// Shared types and constants for the DDR3 device-side command decoder.
// Command encodings match the {ras_n,cas_n,we_n} pin pattern directly.
package ddr3_dec_pkg;

  localparam int MEM_BA_WIDTH  = 3;
  localparam int MEM_ROW_WIDTH = 14;

  localparam int T_RCD_DEF = 6;
  localparam int T_RP_DEF  = 6;
  localparam int T_RAS_DEF = 15;

  localparam int CL_OFS    = 4;
  localparam int CWL_OFS   = 5;
  localparam int BL8_WIN   = 4;
  localparam int WIN_DEPTH = 16;
  localparam int TMR_W     = 5;

  typedef enum logic [3:0] {
    CMD_MRS = 4'd0,
    CMD_REF = 4'd1,
    CMD_PRE = 4'd2,
    CMD_ACT = 4'd3,
    CMD_WR  = 4'd4,
    CMD_RD  = 4'd5,
    CMD_ZQC = 4'd6,
    CMD_NOP = 4'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE      = 4'd0,
    ERR_ACT_OPEN  = 4'd1,
    ERR_RW_CLOSED = 4'd2,
    ERR_TRCD      = 4'd3,
    ERR_TRP       = 4'd4,
    ERR_TRAS      = 4'd5,
    ERR_REF_OPEN  = 4'd6,
    ERR_BUS       = 4'd7
  } err_e;

  // Burst window bits placed so bit `lat` reaches the shift-register tail `lat` edges later.
  function automatic logic [WIN_DEPTH-1:0] win_mask(input logic [3:0] lat);
    logic [WIN_DEPTH-1:0] m;
    m = '0;
    m[BL8_WIN-1:0] = '1;
    return m << lat;
  endfunction

endpackage

// File: rtl/ddr3_bank_trk.sv
// Per-bank state: open flag, active row, and saturating timers since ACT and PRE.
// Violation outputs compare the elapsed count seen at the current edge.
module ddr3_bank_trk
  import ddr3_dec_pkg::*;
#(
  parameter int ROW_WIDTH = MEM_ROW_WIDTH,
  parameter int T_RCD     = T_RCD_DEF,
  parameter int T_RP      = T_RP_DEF,
  parameter int T_RAS     = T_RAS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 act_i,
  input  logic                 close_i,
  input  logic [ROW_WIDTH-1:0] row_i,
  output logic                 open_o,
  output logic [ROW_WIDTH-1:0] row_o,
  output logic                 trcd_viol_o,
  output logic                 trp_viol_o,
  output logic                 tras_viol_o
);

  localparam logic [TMR_W-1:0] TMR_SAT = '1;
  localparam logic [TMR_W-1:0] TRCD_C  = TMR_W'(T_RCD);
  localparam logic [TMR_W-1:0] TRP_C   = TMR_W'(T_RP);
  localparam logic [TMR_W-1:0] TRAS_C  = TMR_W'(T_RAS);

  logic                 open_q, open_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [TMR_W-1:0]     act_tmr_q, act_tmr_d;
  logic [TMR_W-1:0]     pre_tmr_q, pre_tmr_d;

  always_comb begin
    open_d    = open_q;
    row_d     = row_q;
    act_tmr_d = (act_tmr_q == TMR_SAT) ? act_tmr_q : act_tmr_q + 1'b1;
    pre_tmr_d = (pre_tmr_q == TMR_SAT) ? pre_tmr_q : pre_tmr_q + 1'b1;
    if (act_i) begin
      open_d    = 1'b1;
      row_d     = row_i;
      act_tmr_d = TMR_W'(1);
    end else if (close_i && open_q) begin
      // Closing an idle bank must not restart tRP.
      open_d    = 1'b0;
      pre_tmr_d = TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q    <= 1'b0;
      row_q     <= '0;
      act_tmr_q <= TMR_SAT;
      pre_tmr_q <= TMR_SAT;
    end else begin
      open_q    <= open_d;
      row_q     <= row_d;
      act_tmr_q <= act_tmr_d;
      pre_tmr_q <= pre_tmr_d;
    end
  end

  assign open_o      = open_q;
  assign row_o       = row_q;
  assign trcd_viol_o = act_tmr_q < TRCD_C;
  assign trp_viol_o  = pre_tmr_q < TRP_C;
  assign tras_viol_o = act_tmr_q < TRAS_C;

endmodule

// File: rtl/ddr3_cmd_decoder.sv
// DDR3 device-side command decoder: registered decode, MR capture, CL/CWL data windows,
// per-bank tracking and a prioritised protocol error report. Outputs are pulses without backpressure.
module ddr3_cmd_decoder
  import ddr3_dec_pkg::*;
#(
  parameter int BA_WIDTH  = MEM_BA_WIDTH,
  parameter int ROW_WIDTH = MEM_ROW_WIDTH,
  parameter int COL_WIDTH = 10,
  parameter int T_RCD     = T_RCD_DEF,
  parameter int T_RP      = T_RP_DEF,
  parameter int T_RAS     = T_RAS_DEF
) (
  input  logic                       ck_p,
  input  logic                       reset_n,
  input  logic                       cke,
  input  logic                       cs_n,
  input  logic                       ras_n,
  input  logic                       cas_n,
  input  logic                       we_n,
  input  logic [BA_WIDTH-1:0]        ba,
  input  logic [ROW_WIDTH-1:0]       addr,
  output logic                       cmd_vld,
  output logic [3:0]                 cmd_code,
  output logic [BA_WIDTH-1:0]        cmd_ba,
  output logic [ROW_WIDTH-1:0]       cmd_row,
  output logic [COL_WIDTH-1:0]       cmd_col,
  output logic                       cmd_ap,
  output logic [(2**BA_WIDTH)-1:0]   bank_open,
  output logic [ROW_WIDTH-1:0]       mr0,
  output logic [ROW_WIDTH-1:0]       mr2,
  output logic                       rd_en,
  output logic                       wr_en,
  output logic                       err_vld,
  output logic [3:0]                 err_code
);

  localparam int NBANK = 2**BA_WIDTH;

  cmd_e pin_cmd;
  logic dec_vld;
  logic is_rd, is_wr;

  assign pin_cmd = cmd_e'({1'b0, ras_n, cas_n, we_n});
  assign dec_vld = cke && !cs_n && (pin_cmd != CMD_NOP);
  assign is_rd   = dec_vld && (pin_cmd == CMD_RD);
  assign is_wr   = dec_vld && (pin_cmd == CMD_WR);

  logic [NBANK-1:0]     act_v, close_v, open_v, trcd_v, trp_v, tras_v;
  logic [ROW_WIDTH-1:0] row_v [NBANK];

  for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
    ddr3_bank_trk #(
      .ROW_WIDTH (ROW_WIDTH),
      .T_RCD     (T_RCD),
      .T_RP      (T_RP),
      .T_RAS     (T_RAS)
    ) u_trk (
      .clk         (ck_p),
      .rst_n       (reset_n),
      .act_i       (act_v[gb]),
      .close_i     (close_v[gb]),
      .row_i       (addr),
      .open_o      (open_v[gb]),
      .row_o       (row_v[gb]),
      .trcd_viol_o (trcd_v[gb]),
      .trp_viol_o  (trp_v[gb]),
      .tras_viol_o (tras_v[gb])
    );
  end

  // Column address skips A10, which carries auto-precharge.
  logic [COL_WIDTH-1:0] col_sel;
  for (genvar gi = 0; gi < COL_WIDTH; gi++) begin : g_col
    assign col_sel[gi] = addr[(gi < 10) ? gi : gi + 1];
  end

  logic                  cmd_vld_q, cmd_vld_d;
  cmd_e                  cmd_code_q, cmd_code_d;
  logic [BA_WIDTH-1:0]   cmd_ba_q, cmd_ba_d;
  logic [ROW_WIDTH-1:0]  cmd_row_q, cmd_row_d;
  logic [COL_WIDTH-1:0]  cmd_col_q, cmd_col_d;
  logic                  cmd_ap_q, cmd_ap_d;
  logic [ROW_WIDTH-1:0]  mr0_q, mr0_d, mr2_q, mr2_d;
  logic [WIN_DEPTH-1:0]  rd_sr_q, rd_sr_d, wr_sr_q, wr_sr_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                  err_vld_q, err_vld_d;
  err_e                  err_code_q, err_code_d;
  logic [3:0]            cl, cwl;

  assign cl  = {1'b0, mr0_q[6:4]} + 4'(CL_OFS);
  assign cwl = {1'b0, mr2_q[5:3]} + 4'(CWL_OFS);

  always_comb begin
    act_v   = '0;
    close_v = '0;
    if (dec_vld) begin
      case (pin_cmd)
        CMD_ACT: act_v[ba] = 1'b1;
        CMD_PRE: begin
          if (addr[10]) close_v = '1;
          else          close_v[ba] = 1'b1;
        end
        CMD_RD, CMD_WR: close_v[ba] = addr[10];
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_vld_d  = dec_vld;
    cmd_code_d = cmd_code_q;
    cmd_ba_d   = cmd_ba_q;
    cmd_row_d  = cmd_row_q;
    cmd_col_d  = cmd_col_q;
    cmd_ap_d   = cmd_ap_q;
    mr0_d      = mr0_q;
    mr2_d      = mr2_q;
    if (dec_vld) begin
      cmd_code_d = pin_cmd;
      cmd_ba_d   = ba;
      cmd_row_d  = (is_rd || is_wr) ? row_v[ba] : addr;
      cmd_col_d  = col_sel;
      cmd_ap_d   = (is_rd || is_wr) && addr[10];
      if (pin_cmd == CMD_MRS && ba == BA_WIDTH'(0)) mr0_d = addr;
      if (pin_cmd == CMD_MRS && ba == BA_WIDTH'(2)) mr2_d = addr;
    end
  end

  // Latency is frozen into the shift register when the command is taken.
  always_comb begin
    rd_sr_d = rd_sr_q >> 1;
    wr_sr_d = wr_sr_q >> 1;
    if (is_rd && open_v[ba]) rd_sr_d = rd_sr_d | win_mask(cl);
    if (is_wr && open_v[ba]) wr_sr_d = wr_sr_d | win_mask(cwl);
    rd_en_d = rd_sr_q[0];
    wr_en_d = wr_sr_q[0];
  end

  always_comb begin
    err_code_d = ERR_NONE;
    if (dec_vld) begin
      case (pin_cmd)
        CMD_ACT: begin
          if (open_v[ba])     err_code_d = ERR_ACT_OPEN;
          else if (trp_v[ba]) err_code_d = ERR_TRP;
        end
        CMD_RD, CMD_WR: begin
          if (!open_v[ba])     err_code_d = ERR_RW_CLOSED;
          else if (trcd_v[ba]) err_code_d = ERR_TRCD;
        end
        CMD_PRE: begin
          if (addr[10] ? |(tras_v & open_v) : (open_v[ba] && tras_v[ba]))
            err_code_d = ERR_TRAS;
        end
        CMD_REF: if (|open_v) err_code_d = ERR_REF_OPEN;
        default: ;
      endcase
    end
    if (err_code_d == ERR_NONE && rd_en_d && wr_en_d && !(rd_en_q && wr_en_q))
      err_code_d = ERR_BUS;
    err_vld_d = (err_code_d != ERR_NONE);
  end

  always_ff @(posedge ck_p or negedge reset_n) begin
    if (!reset_n) begin
      cmd_vld_q  <= 1'b0;
      cmd_code_q <= CMD_NOP;
      cmd_ba_q   <= '0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
      cmd_ap_q   <= 1'b0;
      mr0_q      <= '0;
      mr2_q      <= '0;
      rd_sr_q    <= '0;
      wr_sr_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      cmd_vld_q  <= cmd_vld_d;
      cmd_code_q <= cmd_code_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_row_q  <= cmd_row_d;
      cmd_col_q  <= cmd_col_d;
      cmd_ap_q   <= cmd_ap_d;
      mr0_q      <= mr0_d;
      mr2_q      <= mr2_d;
      rd_sr_q    <= rd_sr_d;
      wr_sr_q    <= wr_sr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_vld   = cmd_vld_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_ap    = cmd_ap_q;
  assign bank_open = open_v;
  assign mr0       = mr0_q;
  assign mr2       = mr2_q;
  assign rd_en     = rd_en_q;
  assign wr_en     = wr_en_q;
  assign err_vld   = err_vld_q;
  assign err_code  = err_code_q;

endmodule
